cdc_handshake_controller: RTL

CDC_HANDSHAKE_CONTROLLER -- requirements
Module: cdc_handshake_controller

---
 rtl/cdc_handshake_controller.sv | 83 ++++++++
 1 files changed

// File: rtl/cdc_handshake_controller.sv
// Destination-side controller for a four-phase req/ack clock-domain crossing.
// The request level is synchronized; the data bus is sampled once it is known to be stable.
module cdc_handshake_controller #(
   parameter int STAGE_COUNT = 2,
   parameter int BUS_WIDTH   = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 asynchronous_req,
   input  logic [BUS_WIDTH-1:0] asynchronous_data,
   input  logic                 data_ready,
   output logic                 synchronous_ack,
   output logic [BUS_WIDTH-1:0] synchronous_data,
   output logic                 data_valid,
   output logic                 busy
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HOLD = 2'd1,
      ACK  = 2'd2
   } state_t;

   state_t                 state;
   logic [STAGE_COUNT-1:0] sync_chain;
   logic                   req_s;

   // NOTE: non-blocking assignments make the chain advance exactly one stage per edge.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync_chain <= '0;
      end else begin
         sync_chain <= {sync_chain[STAGE_COUNT-2:0], asynchronous_req};
      end
   end

   assign req_s = sync_chain[STAGE_COUNT-1];

   // NOTE: asynchronous_data is not synchronized; the source holds it stable from req
   // rise until ack rise, so sampling it once req_s is seen high is safe.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state            <= IDLE;
         synchronous_ack  <= 1'b0;
         synchronous_data <= '0;
         data_valid       <= 1'b0;
         busy             <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (req_s) begin
                  synchronous_data <= asynchronous_data;
                  data_valid       <= 1'b1;
                  busy             <= 1'b1;
                  state            <= HOLD;
               end
            end
            // A request dropped early is ignored here; the transfer still completes.
            HOLD: begin
               if (data_ready) begin
                  data_valid      <= 1'b0;
                  synchronous_ack <= 1'b1;
                  state           <= ACK;
               end
            end
            ACK: begin
               if (!req_s) begin
                  synchronous_ack <= 1'b0;
                  busy            <= 1'b0;
                  state           <= IDLE;
               end
            end
            default: begin
               synchronous_ack <= 1'b0;
               data_valid      <= 1'b0;
               busy            <= 1'b0;
               state           <= IDLE;
            end
         endcase
      end
   end

endmodule
